// File: rtl/io_window_ctrl.sv
// Multi-window expansion access decoder. Each window is a 64 KB block on A[23:16]. The block drives
// registered per-window read/write strobes with wait states, DTACK and a recovery gap.
module io_window_ctrl #(
  parameter int NUM_WIN     = 2,
  parameter int WAIT_RD     = 2,
  parameter int WAIT_WR     = 1,
  parameter int RECOVER_CYC = 1
) (
  input  logic                 C7M,
  input  logic                 RESET,
  input  logic [7:0]           A_HIGH,
  input  logic                 RW_n,
  input  logic                 AS_CPU_n,
  input  logic [8*NUM_WIN-1:0] BASE_VEC,
  input  logic [NUM_WIN-1:0]   CONFIGURED_n,
  output logic [NUM_WIN-1:0]   ACCESS,
  output logic [NUM_WIN-1:0]   ROM_OE_n,
  output logic [NUM_WIN-1:0]   ROM_WE_n,
  output logic                 DTACK_n,
  output logic                 BUSY
);

  localparam int IW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam logic [3:0] RD_LOAD  = 4'(WAIT_RD);
  localparam logic [3:0] WR_LOAD  = 4'(WAIT_WR);
  localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYC - 1);

  typedef enum logic [1:0] {IDLE, STROBE, ACK, RECOVER} state_t;

  state_t               state, state_next;
  logic [3:0]           cnt, cnt_next;
  logic [IW-1:0]        idx, idx_next;
  logic                 rw, rw_next;
  logic [NUM_WIN-1:0]   oe_next, we_next;
  logic                 dtack_next;
  logic [1:0]           as_sync;
  logic                 as_s;
  logic                 hit;
  logic [IW-1:0]        hit_idx;

  for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_decode
    assign ACCESS[gi] = !CONFIGURED_n[gi] && (A_HIGH == BASE_VEC[8*gi +: 8]) && !AS_CPU_n;
  end

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (ACCESS[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign as_s = as_sync[1];
  assign BUSY = (state != IDLE);

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      as_sync  <= 2'b11;
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      rw       <= 1'b1;
      ROM_OE_n <= '1;
      ROM_WE_n <= '1;
      DTACK_n  <= 1'b1;
    end else begin
      as_sync  <= {as_sync[0], AS_CPU_n};
      state    <= state_next;
      cnt      <= cnt_next;
      idx      <= idx_next;
      rw       <= rw_next;
      ROM_OE_n <= oe_next;
      ROM_WE_n <= we_next;
      DTACK_n  <= dtack_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    rw_next    = rw;
    oe_next    = '1;
    we_next    = '1;
    dtack_next = 1'b1;
    case (state)
      IDLE: begin
        if (!as_s && hit) begin
          state_next = STROBE;
          idx_next   = hit_idx;
          rw_next    = RW_n;
          cnt_next   = RW_n ? RD_LOAD : WR_LOAD;
          if (RW_n) oe_next[hit_idx] = 1'b0;
          else      we_next[hit_idx] = 1'b0;
        end
      end
      STROBE: begin
        if (as_s) begin
          // CPU gave up before acknowledge: drop the strobe, never assert DTACK.
          state_next = RECOVER;
          cnt_next   = REC_LOAD;
        end else begin
          if (cnt == 4'd0) begin
            state_next = ACK;
            dtack_next = 1'b0;
          end else begin
            cnt_next = cnt - 4'd1;
          end
          if (rw) oe_next[idx] = 1'b0;
          else    we_next[idx] = 1'b0;
        end
      end
      ACK: begin
        if (as_s) begin
          state_next = RECOVER;
          cnt_next   = REC_LOAD;
        end else begin
          dtack_next = 1'b0;
          if (rw) oe_next[idx] = 1'b0;
          else    we_next[idx] = 1'b0;
        end
      end
      RECOVER: begin
        if (cnt == 4'd0) state_next = IDLE;
        else             cnt_next   = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_window_ctrl.sv
// Directed bench for io_window_ctrl. Instance a uses WAIT_RD=2 and WAIT_WR=0.
// Instance b uses WAIT_RD=4 and is used for the abort case.
module tb_io_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_high;
  logic        rw_n;
  logic        as_n;
  logic [15:0] base_vec;
  logic [1:0]  cfg_n;

  logic [1:0]  access_a, oe_a, we_a, access_b, oe_b, we_b;
  logic        dtack_a, busy_a, dtack_b, busy_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_window_ctrl #(.NUM_WIN(2), .WAIT_RD(2), .WAIT_WR(0), .RECOVER_CYC(1)) dut_a (
    .C7M(clk), .RESET(rst), .A_HIGH(a_high), .RW_n(rw_n), .AS_CPU_n(as_n),
    .BASE_VEC(base_vec), .CONFIGURED_n(cfg_n), .ACCESS(access_a),
    .ROM_OE_n(oe_a), .ROM_WE_n(we_a), .DTACK_n(dtack_a), .BUSY(busy_a)
  );

  io_window_ctrl #(.NUM_WIN(2), .WAIT_RD(4), .WAIT_WR(1), .RECOVER_CYC(1)) dut_b (
    .C7M(clk), .RESET(rst), .A_HIGH(a_high), .RW_n(rw_n), .AS_CPU_n(as_n),
    .BASE_VEC(base_vec), .CONFIGURED_n(cfg_n), .ACCESS(access_b),
    .ROM_OE_n(oe_b), .ROM_WE_n(we_b), .DTACK_n(dtack_b), .BUSY(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_access(input logic [7:0] addr, input logic rd);
    @(negedge clk);
    a_high = addr;
    rw_n   = rd;
    as_n   = 1'b0;
  endtask

  task automatic release_as();
    @(negedge clk);
    as_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; as_n = 1'b1; rw_n = 1'b1; a_high = 8'h00;
    base_vec = {8'hEA, 8'hE9}; cfg_n = 2'b00;
    #1;
    checks++;
    if (oe_a !== 2'b11 || we_a !== 2'b11 || dtack_a !== 1'b1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got oe=%b we=%b dtack=%b busy=%b want 11 11 1 0", oe_a, we_a, dtack_a, busy_a);
    end
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    $display("reset: done");
  endtask

  task automatic test_read_window1();
    start_access(8'hEA, 1'b1);
    tick(); // edge 0
    checks++;
    if (access_a !== 2'b10) begin
      failures++; $display("FAIL rd_access got=%b want=10", access_a);
    end
    tick(); // edge 1
    checks++;
    if (oe_a !== 2'b11) begin
      failures++; $display("FAIL rd_oe_e1 got=%b want=11", oe_a);
    end
    tick(); // edge 2
    checks++;
    if (oe_a !== 2'b01 || busy_a !== 1'b1 || dtack_a !== 1'b1) begin
      failures++; $display("FAIL rd_e2 got oe=%b busy=%b dtack=%b want 01 1 1", oe_a, busy_a, dtack_a);
    end
    tick(); tick(); // edge 4
    checks++;
    if (dtack_a !== 1'b1) begin
      failures++; $display("FAIL rd_dtack_e4 got=%b want=1", dtack_a);
    end
    tick(); // edge 5
    checks++;
    if (dtack_a !== 1'b0 || oe_a !== 2'b01) begin
      failures++; $display("FAIL rd_e5 got dtack=%b oe=%b want 0 01", dtack_a, oe_a);
    end
    release_as();
    tick(); tick(); // edge 7: as_s just went high
    checks++;
    if (dtack_a !== 1'b0 || oe_a !== 2'b01) begin
      failures++; $display("FAIL rd_e7 got dtack=%b oe=%b want 0 01", dtack_a, oe_a);
    end
    tick(); // edge 8
    checks++;
    if (dtack_a !== 1'b1 || oe_a !== 2'b11 || busy_a !== 1'b1) begin
      failures++; $display("FAIL rd_e8 got dtack=%b oe=%b busy=%b want 1 11 1", dtack_a, oe_a, busy_a);
    end
    tick(); // edge 9
    checks++;
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL rd_busy_e9 got=%b want=0", busy_a);
    end
    repeat (10) tick();
    $display("read_window1: done");
  endtask

  task automatic test_write_wait0();
    start_access(8'hE9, 1'b0);
    tick(); tick(); tick(); // edge 2
    checks++;
    if (we_a !== 2'b10 || oe_a !== 2'b11 || dtack_a !== 1'b1) begin
      failures++; $display("FAIL wr_e2 got we=%b oe=%b dtack=%b want 10 11 1", we_a, oe_a, dtack_a);
    end
    tick(); // edge 3
    checks++;
    if (dtack_a !== 1'b0 || we_a !== 2'b10 || oe_a !== 2'b11) begin
      failures++; $display("FAIL wr_e3 got dtack=%b we=%b oe=%b want 0 10 11", dtack_a, we_a, oe_a);
    end
    release_as();
    repeat (4) tick();
    checks++;
    if (we_a !== 2'b11 || oe_a !== 2'b11 || dtack_a !== 1'b1 || busy_a !== 1'b0) begin
      failures++; $display("FAIL wr_end got we=%b oe=%b dtack=%b busy=%b want 11 11 1 0", we_a, oe_a, dtack_a, busy_a);
    end
    repeat (10) tick();
    $display("write_wait0: done");
  endtask

  task automatic test_overlap();
    @(negedge clk);
    base_vec = {8'hE9, 8'hE9};
    start_access(8'hE9, 1'b1);
    #1;
    checks++;
    if (access_a !== 2'b11) begin
      failures++; $display("FAIL ovl_access got=%b want=11", access_a);
    end
    tick(); tick(); tick(); // edge 2
    checks++;
    if (oe_a !== 2'b10) begin
      failures++; $display("FAIL ovl_oe got=%b want=10", oe_a);
    end
    release_as();
    repeat (12) tick();
    base_vec = {8'hEA, 8'hE9};
    $display("overlap: done");
  endtask

  task automatic test_unconfigured();
    @(negedge clk);
    cfg_n = 2'b11;
    start_access(8'hE9, 1'b1);
    #1;
    checks++;
    if (access_a !== 2'b00) begin
      failures++; $display("FAIL uncfg_access got=%b want=00", access_a);
    end
    for (int e = 0; e < 6; e++) begin
      tick();
      checks++;
      if (oe_a !== 2'b11 || we_a !== 2'b11 || dtack_a !== 1'b1 || busy_a !== 1'b0) begin
        failures++;
        $display("FAIL uncfg_e%0d got oe=%b we=%b dtack=%b busy=%b want 11 11 1 0", e, oe_a, we_a, dtack_a, busy_a);
      end
    end
    release_as();
    @(negedge clk);
    cfg_n = 2'b00;
    repeat (6) tick();
    $display("unconfigured: done");
  endtask

  task automatic test_abort();
    start_access(8'hE9, 1'b1);
    tick(); tick(); tick(); // edge 2
    checks++;
    if (oe_b !== 2'b10) begin
      failures++; $display("FAIL abort_oe_e2 got=%b want=10", oe_b);
    end
    tick(); // edge 3
    release_as();
    for (int e = 4; e <= 8; e++) begin
      tick();
      checks++;
      if (dtack_b !== 1'b1) begin
        failures++; $display("FAIL abort_dtack_e%0d got=%b want=1", e, dtack_b);
      end
      if (e == 5) begin
        checks++;
        if (oe_b !== 2'b10) begin
          failures++; $display("FAIL abort_oe_e5 got=%b want=10", oe_b);
        end
      end
      if (e == 6) begin
        checks++;
        if (oe_b !== 2'b11 || busy_b !== 1'b1) begin
          failures++; $display("FAIL abort_e6 got oe=%b busy=%b want 11 1", oe_b, busy_b);
        end
      end
      if (e == 7) begin
        checks++;
        if (busy_b !== 1'b0) begin
          failures++; $display("FAIL abort_busy_e7 got=%b want=0", busy_b);
        end
      end
    end
    repeat (10) tick();
    $display("abort: done");
  endtask

  task automatic test_reset_in_ack();
    start_access(8'hE9, 1'b1);
    repeat (6) tick(); // edge 5
    checks++;
    if (dtack_a !== 1'b0) begin
      failures++; $display("FAIL rack_pre got dtack=%b want=0", dtack_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (oe_a !== 2'b11 || dtack_a !== 1'b1 || busy_a !== 1'b0) begin
      failures++; $display("FAIL rack_async got oe=%b dtack=%b busy=%b want 11 1 0", oe_a, dtack_a, busy_a);
    end
    release_as();
    tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    start_access(8'hE9, 1'b1);
    tick(); tick(); tick(); // edge 2
    checks++;
    if (oe_a !== 2'b10) begin
      failures++; $display("FAIL rack_next_oe got=%b want=10", oe_a);
    end
    tick(); tick(); tick(); // edge 5
    checks++;
    if (dtack_a !== 1'b0) begin
      failures++; $display("FAIL rack_next_dtack got=%b want=0", dtack_a);
    end
    release_as();
    repeat (10) tick();
    $display("reset_in_ack: done");
  endtask

  initial begin
    test_reset();
    test_read_window1();
    test_write_wait0();
    test_overlap();
    test_unconfigured();
    test_abort();
    test_reset_in_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_window_ctrl.md
Name: io_window_ctrl

Overview:
- Parametrised successor to the single-window expansion access decoder.
- Decodes up to NUM_WIN autoconfigured 64 KB windows on A[23:16] against the CPU address strobe.
- Drives a per-window registered read strobe (OE_n) and write strobe (WE_n), with programmable wait states.
- Generates DTACK_n and a recovery gap; sits between the CPU bus and the on-board ROM/IO devices.

Parameters:
- NUM_WIN, 2: number of independent address windows (1..8).
- WAIT_RD, 2: C7M cycles inserted between read-strobe assertion and DTACK (0..15).
- WAIT_WR, 1: C7M cycles inserted between write-strobe assertion and DTACK (0..15).
- RECOVER_CYC, 1: C7M cycles with all strobes negated after an access ends (1..15).

Ports:
- C7M  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- A_HIGH  input  8  CPU address bits 23:16.
- RW_n  input  1  CPU read (1) / write (0).
- AS_CPU_n  input  1  CPU address strobe, asynchronous to C7M, active low.
- BASE_VEC  input  8*NUM_WIN  window bases; window i uses bits [8i+7:8i].
- CONFIGURED_n  input  NUM_WIN  per-window configured flag, active low.
- ACCESS  output  NUM_WIN  combinational decode: bit i = !CONFIGURED_n[i] && A_HIGH==base[i] && !AS_CPU_n.
- ROM_OE_n  output  NUM_WIN  registered per-window read strobe, active low.
- ROM_WE_n  output  NUM_WIN  registered per-window write strobe, active low.
- DTACK_n  output  1  registered data-transfer acknowledge, active low.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset (RESET high, asynchronous):
  - ROM_OE_n and ROM_WE_n all ones; DTACK_n=1; BUSY=0.
  - State=IDLE; wait counter=0.
  - Synchroniser flops set to 1 (strobe negated).
- AS_CPU_n passes through a 2-flop synchroniser (as_s).
- A_HIGH, RW_n and BASE_VEC are treated as stable while AS_CPU_n is low.
- Hit selection: lowest-index window with its ACCESS condition true wins; overlapping bases never assert two strobes.
- States: IDLE, STROBE, ACK, RECOVER.
- IDLE:
  - Condition: as_s low and at least one hit.
  - Action: latch window index and RW_n; enter STROBE.
  - Strobes: same edge, assert OE_n[idx] if read, WE_n[idx] if write.
  - Counter load: WAIT_RD (read) or WAIT_WR (write).
- STROBE:
  - Counter==0: next edge enters ACK and drives DTACK_n=0; strobe held.
  - Counter!=0: counter decrements.
- ACK:
  - Hold strobe and DTACK_n=0 while as_s low.
  - On as_s high: enter RECOVER; negate strobe and DTACK_n on that edge; counter loads RECOVER_CYC-1.
- RECOVER:
  - All strobes and DTACK_n negated.
  - Counter==0: IDLE next edge; else decrement.
  - A new AS during RECOVER is not accepted until IDLE.
- Abort: as_s high while in STROBE → RECOVER on the next edge; strobe negated and DTACK_n never asserted.
- Decode and CONFIGURED_n are sampled only in IDLE; changes mid-access do not affect the access in progress.
- Miss (as_s low, no hit): stay in IDLE; all outputs negated; BUSY=0.
- Timing with AS_CPU_n falling before edge 0 (setup met):
  - Edge 1: as_s low.
  - Edge 2: strobe asserted.
  - Edge 2+WAIT+1: DTACK_n low.
- WAIT=0 gives DTACK one edge after the strobe.
- Reset mid-access forces the reset values immediately, irrespective of state.
- ACCESS remains purely combinational and is unaffected by the state machine.

Test Plan:
- NUM_WIN=2, bases 0xE9/0xEA, both configured, read at A_HIGH=0xEA, WAIT_RD=2:
  - ROM_OE_n=2'b01 from edge 2; DTACK_n low at edge 5.
  - AS release → both negated one edge after as_s high.
  - BUSY low RECOVER_CYC edges later.
- Write to 0xE9 with WAIT_WR=0:
  - ROM_WE_n=2'b10 at edge 2; DTACK_n low at edge 3.
  - ROM_OE_n stays 2'b11 throughout.
- Both windows set to base 0xE9, read at 0xE9:
  - Only ROM_OE_n[0] asserts.
  - ACCESS=2'b11 while AS is low.
- CONFIGURED_n=2'b11, AS low at 0xE9:
  - ACCESS=0, strobes stay high, DTACK_n stays high, BUSY=0.
- WAIT_RD=4; AS released one edge after strobe assertion:
  - Abort to RECOVER; DTACK_n never goes low; ROM_OE_n negated.
- RESET pulsed high while in ACK:
  - All strobes and DTACK_n high, BUSY=0 without waiting for a clock edge.
  - Next AS gives a normal access.
